// File: rtl/fetch_requester.sv
// Fetch request generator: issues sequential aligned reads, one outstanding,
// and forwards responses into a 1-deep buffer's write side.
//
// Ports:
//   Clk, Rst            clock, synchronous active-low reset
//   Redirect/RedirectPc restart fetch stream at RedirectPc (priority event)
//   ReqValid/ReqReady/  read request channel (valid/ready)
//   ReqAddr
//   RespValid/RespData  read response, single-cycle, no back-pressure
//   BufWData/BufWInc/   buffer write port and full flag
//   BufWFull
module fetch_requester #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter logic [AddrWidth-1:0] ResetPc = AddrWidth'(64'h0000_0000_8000_0000)
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Redirect,
  input  logic [AddrWidth-1:0] RedirectPc,
  output logic                 ReqValid,
  output logic [AddrWidth-1:0] ReqAddr,
  input  logic                 ReqReady,
  input  logic                 RespValid,
  input  logic [DataWidth-1:0] RespData,
  output logic [DataWidth-1:0] BufWData,
  output logic                 BufWInc,
  input  logic                 BufWFull
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } state_t;

  localparam logic [AddrWidth-1:0] Step = AddrWidth'(DataWidth / 8);

  state_t               state, state_n;
  logic [AddrWidth-1:0] pc, pc_n;
  logic [AddrWidth-1:0] addr, addr_n;
  logic                 kill, kill_n;
  logic [DataWidth-1:0] hold, hold_n;
  logic                 accept;

  assign accept  = ReqReady && (state == REQ);
  assign ReqAddr = addr;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state <= IDLE;
      pc    <= ResetPc;
      addr  <= ResetPc;
      kill  <= 1'b0;
      hold  <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      addr  <= addr_n;
      kill  <= kill_n;
      hold  <= hold_n;
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    kill_n   = kill;
    hold_n   = hold;
    ReqValid = 1'b0;
    BufWInc  = 1'b0;
    BufWData = '0;
    unique case (state)
      IDLE: begin
        state_n = REQ;
        if (Redirect) pc_n = RedirectPc;
      end
      REQ: begin
        ReqValid = 1'b1;
        // A redirect while presenting keeps the old request on the bus;
        // its response is marked for discard via kill.
        if (Redirect) begin
          pc_n   = RedirectPc;
          kill_n = 1'b1;
        end else if (accept && !kill) begin
          pc_n = pc + Step;
        end
        if (accept) state_n = WAIT;
      end
      WAIT: begin
        if (RespValid) begin
          if (kill || Redirect) begin
            kill_n  = 1'b0;
            state_n = REQ;
            if (Redirect) pc_n = RedirectPc;
          end else if (!BufWFull) begin
            BufWInc  = 1'b1;
            BufWData = RespData;
            state_n  = REQ;
          end else begin
            hold_n  = RespData;
            state_n = HOLD;
          end
        end else if (Redirect) begin
          kill_n = 1'b1;
          pc_n   = RedirectPc;
        end
      end
      HOLD: begin
        BufWData = hold;
        if (Redirect) begin
          pc_n    = RedirectPc;
          state_n = REQ;
        end else if (!BufWFull) begin
          BufWInc = 1'b1;
          state_n = REQ;
        end
      end
      default: state_n = IDLE;
    endcase
    // Request address is frozen while presenting, otherwise tracks pc.
    addr_n = (state == REQ) ? addr : pc_n;
  end

endmodule

// File: tb/tb_fetch_requester.sv
// Randomized scoreboard bench for fetch_requester.
// Reference model tracks the fetch stream at the transaction level.
module tb_fetch_requester;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Redirect = 1'b0;
  logic [63:0] RedirectPc = '0;
  logic        ReqValid;
  logic [63:0] ReqAddr;
  logic        ReqReady = 1'b0;
  logic        RespValid = 1'b0;
  logic [63:0] RespData = '0;
  logic [63:0] BufWData;
  logic        BufWInc;
  logic        BufWFull = 1'b0;

  fetch_requester dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Redirect  (Redirect),
    .RedirectPc(RedirectPc),
    .ReqValid  (ReqValid),
    .ReqAddr   (ReqAddr),
    .ReqReady  (ReqReady),
    .RespValid (RespValid),
    .RespData  (RespData),
    .BufWData  (BufWData),
    .BufWInc   (BufWInc),
    .BufWFull  (BufWFull)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;
  int pushed = 0;
  int popped = 0;

  logic [63:0] exp_wr_q[$];
  logic [63:0] exp_addr_q[$];

  // model: stream pointer, presented request, outstanding read, held word
  logic [63:0] ptr;
  logic [63:0] pres_addr;
  logic [63:0] held_data;
  bit          pres_void;
  bit          out_valid;
  bit          out_void;
  int          out_delay;
  bit          held;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    ptr       = RST_PC;
    pres_addr = RST_PC;
    pres_void = 1'b0;
    out_valid = 1'b0;
    out_void  = 1'b0;
    out_delay = 0;
    held      = 1'b0;
    exp_wr_q.delete();
    exp_addr_q.delete();
  endtask

  task automatic push_wr(input logic [63:0] d);
    exp_wr_q.push_back(d);
    pushed++;
  endtask

  // Drive one cycle of inputs and advance the model by that cycle.
  task automatic drive_cycle(input bit rd, input logic [63:0] rpc,
                             input bit rdy, input bit full);
    bit          rv_dut;
    bit          acc;
    bit          resp;
    bit          held_before;
    logic [63:0] d;
    resp = out_valid && (out_delay == 0);
    if (out_valid && out_delay > 0) out_delay--;
    d = {$urandom, $urandom};
    Redirect   = rd;
    RedirectPc = rpc;
    ReqReady   = rdy;
    BufWFull   = full;
    RespValid  = resp;
    RespData   = resp ? d : 64'h0;
    rv_dut      = ReqValid;
    held_before = held;
    if (rv_dut && !pres_void) pres_addr = ptr;
    acc = rv_dut && rdy;
    if (acc) begin
      exp_addr_q.push_back(pres_addr);
      if (!pres_void && !rd) ptr = ptr + 64'd8;
      out_valid = 1'b1;
      out_void  = pres_void || rd;
      out_delay = $urandom_range(0, 2);
      pres_void = 1'b0;
    end else if (rv_dut && rd) begin
      pres_void = 1'b1;
    end
    if (resp) begin
      out_valid = 1'b0;
      if (!out_void && !rd) begin
        if (!full) push_wr(d);
        else begin
          held      = 1'b1;
          held_data = d;
        end
      end
    end else if (out_valid && !acc && rd) begin
      out_void = 1'b1;
    end
    if (held_before) begin
      if (rd) held = 1'b0;
      else if (!full) begin
        push_wr(held_data);
        held = 1'b0;
      end
    end
    if (rd) ptr = rpc;
  endtask

  // Monitor: compares DUT activity against the scoreboard queues.
  bit          prev_stall = 1'b0;
  logic [63:0] prev_addr = '0;
  logic [63:0] e;

  always @(negedge Clk) begin
    if (!Rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("req_valid_held", {63'd0, ReqValid}, 64'd1);
        chk("req_addr_held", ReqAddr, prev_addr);
      end
      if (BufWInc) begin
        chk("winc_while_full", {63'd0, BufWFull}, 64'd0);
        if (exp_wr_q.size() == 0) begin
          chk("unexpected_winc", 64'd1, 64'd0);
        end else begin
          e = exp_wr_q.pop_front();
          popped++;
          chk("wdata", BufWData, e);
        end
      end
      if (ReqValid && ReqReady) begin
        if (exp_addr_q.size() == 0) begin
          chk("unexpected_accept", 64'd1, 64'd0);
        end else begin
          e = exp_addr_q.pop_front();
          chk("req_addr", ReqAddr, e);
        end
      end
      prev_stall = ReqValid && !ReqReady;
      prev_addr  = ReqAddr;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, {63'd0, ReqValid}, 64'd0);
    chk({tag, "_req_addr"}, ReqAddr, RST_PC);
    chk({tag, "_winc"}, {63'd0, BufWInc}, 64'd0);
    chk({tag, "_wdata"}, BufWData, 64'd0);
  endtask

  task automatic random_run(input int n);
    bit          rd;
    logic [63:0] rpc;
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
      rd  = ($urandom_range(0, 11) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0
                                        : ({$urandom, $urandom} & ~64'h7);
      drive_cycle(rd, rpc, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 9) < 3);
    end
  endtask

  int n;

  initial begin
    model_reset();
    Rst = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check_reset_outputs("reset");
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    model_reset();
    drive_cycle(1'b0, 64'h0, 1'b0, 1'b0);
    // stalled request, then back-to-back sequential fetches
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk);
      #1;
      drive_cycle(1'b0, 64'h0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk);
      #1;
      drive_cycle(1'b0, 64'h0, 1'b1, 1'b0);
    end
    random_run(1500);
    // reach WAIT, then reset mid-transaction
    n = 0;
    do begin
      @(posedge Clk);
      #1;
      drive_cycle(1'b0, 64'h0, 1'b1, 1'b0);
      n++;
    end while (!(out_valid && out_delay > 0) && n < 50);
    chk("wait_reached", {63'd0, n < 50}, 64'd1);
    @(posedge Clk);
    #1;
    Rst       = 1'b0;
    Redirect  = 1'b0;
    RespValid = 1'b0;
    ReqReady  = 1'b0;
    BufWFull  = 1'b0;
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    model_reset();
    RespValid = 1'b1;
    RespData  = 64'hDEAD_BEEF;
    @(negedge Clk);
    check_reset_outputs("midreset");
    @(posedge Clk);
    #1;
    RespValid = 1'b1;
    RespData  = 64'hBAAD_F00D;
    @(posedge Clk);
    #1;
    drive_cycle(1'b0, 64'h0, 1'b1, 1'b0);
    random_run(400);
    // drain: no redirects, buffer free, until nothing is pending
    n = 0;
    while ((out_valid || held) && n < 20) begin
      @(posedge Clk);
      #1;
      drive_cycle(1'b0, 64'h0, 1'b0, 1'b0);
      n++;
    end
    @(posedge Clk);
    #1;
    Redirect  = 1'b0;
    RespValid = 1'b0;
    ReqReady  = 1'b0;
    @(negedge Clk);
    chk("drain_done", {63'd0, n < 20}, 64'd1);
    chk("wr_queue_empty", 64'(exp_wr_q.size()), 64'd0);
    chk("addr_queue_empty", 64'(exp_addr_q.size()), 64'd0);
    chk("writes_seen", {63'd0, popped > 50}, 64'd1);
    chk("writes_match", 64'(popped), 64'(pushed));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
